// File: rtl/serial_thermometer_to_scomp_pkg.sv
// Shared frame geometry and FSM encoding for the serial thermometer datapath.
// The encode and decode stages both derive their frame length from these helpers.
package serial_thermometer_to_scomp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // A magnitude of INPUT_WIDTH bits needs 2**INPUT_WIDTH-1 thermometer bits.
   function automatic int frame_len(input int iw);
      return (1 << iw) - 1;
   endfunction

   function automatic int out_width(input int iw);
      return iw + 1;
   endfunction

endpackage

// File: rtl/serial_thermometer_to_scomp_acc.sv
// Ones counter and bubble detector for one serial thermometer frame.
// The *_nxt outputs include the current beat so the last bit lands in the result.
module thermo_bit_accumulator #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic         in_bit,
   output logic [W-1:0] ones_nxt,
   output logic         error_nxt
);

   logic [W-1:0] ones_cnt;
   logic         seen_zero;
   logic         error;
   logic         seen_zero_nxt;

   // A frame never holds more than 2**W-1 bits, so the count cannot wrap.
   always_comb begin
      ones_nxt      = ones_cnt;
      error_nxt     = error;
      seen_zero_nxt = seen_zero;
      if (load) begin
         ones_nxt      = W'(in_bit);
         error_nxt     = 1'b0;
         seen_zero_nxt = ~in_bit;
      end else if (step) begin
         ones_nxt      = ones_cnt + W'(in_bit);
         error_nxt     = error | (in_bit & seen_zero);
         seen_zero_nxt = seen_zero | ~in_bit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_cnt  <= '0;
         seen_zero <= 1'b0;
         error     <= 1'b0;
      end else begin
         ones_cnt  <= ones_nxt;
         seen_zero <= seen_zero_nxt;
         error     <= error_nxt;
      end
   end

endmodule

// File: rtl/serial_thermometer_to_scomp.sv
// Serial MSB-first thermometer frame plus sign bit to two's-complement value.
// Result is held until the consumer handshakes; input is back-pressured meanwhile.
module serial_thermometer_to_scomp
   import serial_thermometer_to_scomp_pkg::*;
#(
   parameter  int INPUT_WIDTH = 3,
   localparam int OUT_WIDTH   = out_width(INPUT_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_start,
   input  logic                 in_bit,
   input  logic                 in_sign,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_error
);

   localparam int FRAME_LEN = frame_len(INPUT_WIDTH);
   localparam logic [INPUT_WIDTH-1:0] LAST_IDX = INPUT_WIDTH'(FRAME_LEN - 1);
   localparam logic [INPUT_WIDTH-1:0] IDX_ONE  = INPUT_WIDTH'(1);

   state_t                 state;
   logic [INPUT_WIDTH-1:0] bit_idx;
   logic [INPUT_WIDTH-1:0] beat_idx;
   logic                   sign_q;
   logic                   sign_eff;
   logic                   accept;
   logic                   load;
   logic                   step;
   logic                   last;
   logic [INPUT_WIDTH-1:0] ones_nxt;
   logic                   err_nxt;
   logic [OUT_WIDTH-1:0]   mag;

   assign in_ready = (state != ST_HOLD);
   assign accept   = in_valid & in_ready;
   // A start beat restarts the frame from IDLE or mid-COLLECT alike.
   assign load     = accept & in_start;
   assign step     = accept & ~in_start & (state == ST_COLLECT);
   assign beat_idx = load ? '0 : bit_idx;
   assign last     = (load | step) & (beat_idx == LAST_IDX);
   assign sign_eff = load ? in_sign : sign_q;
   assign mag      = OUT_WIDTH'(ones_nxt);

   thermo_bit_accumulator #(.W(INPUT_WIDTH)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .in_bit    (in_bit),
      .ones_nxt  (ones_nxt),
      .error_nxt (err_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_idx   <= '0;
         sign_q    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_error <= 1'b0;
      end else begin
         if (load) begin
            sign_q  <= in_sign;
            bit_idx <= IDX_ONE;
         end else if (step) begin
            bit_idx <= bit_idx + IDX_ONE;
         end

         case (state)
            ST_IDLE: begin
               if (load) state <= last ? ST_HOLD : ST_COLLECT;
            end
            ST_COLLECT: begin
               if (last) state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Negating a zero magnitude yields zero, so no negative zero exists.
         if (last) begin
            out_valid <= 1'b1;
            out_data  <= sign_eff ? -mag : mag;
            out_error <= err_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_thermometer_to_scomp.sv
// Directed bench for the serial thermometer to signed converter at INPUT_WIDTH=3.
module tb_serial_thermometer_to_scomp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_start = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_sign = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       out_error;

   int checks = 0;
   int failures = 0;

   serial_thermometer_to_scomp #(.INPUT_WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_start  (in_start),
      .in_bit    (in_bit),
      .in_sign   (in_sign),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_error (out_error)
   );

   always #5 clk = ~clk;

   task automatic drive_beat(input logic s, input logic b, input logic sg);
      @(negedge clk);
      in_valid = 1'b1; in_start = s; in_bit = b; in_sign = sg;
      @(posedge clk); #1;
      in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0; in_sign = 1'b0;
   endtask

   task automatic send_frame(input logic sg, input logic [6:0] bits);
      for (int i = 0; i < 7; i++) drive_beat(i == 0, bits[6-i], sg);
   endtask

   task automatic handshake();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 4'b0000) begin failures++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
      checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL reset_out_error got=%b exp=0", out_error); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_positive();
      logic [6:0] bits = 7'b1111100;
      for (int i = 0; i < 6; i++) drive_beat(i == 0, bits[6-i], 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pos_early_valid got=%b exp=0", out_valid); end
      drive_beat(1'b0, bits[0], 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pos_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'b0101) begin failures++; $display("FAIL pos_data got=%b exp=0101", out_data); end
      checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL pos_error got=%b exp=0", out_error); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pos_in_ready got=%b exp=0", in_ready); end
      handshake();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pos_release_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pos_release_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_negative();
      send_frame(1'b1, 7'b1110000);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL neg3_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'b1101) begin failures++; $display("FAIL neg3_data got=%b exp=1101", out_data); end
      handshake();
      send_frame(1'b1, 7'b0000000);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL negzero_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'b0000) begin failures++; $display("FAIL negzero_data got=%b exp=0000", out_data); end
      checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL negzero_error got=%b exp=0", out_error); end
      handshake();
   endtask

   task automatic test_bubble();
      send_frame(1'b0, 7'b1101000);
      checks++; if (out_data !== 4'b0011) begin failures++; $display("FAIL bubble_data got=%b exp=0011", out_data); end
      checks++; if (out_error !== 1'b1) begin failures++; $display("FAIL bubble_error got=%b exp=1", out_error); end
      handshake();
      send_frame(1'b0, 7'b1100000);
      checks++; if (out_error !== 1'b0) begin failures++; $display("FAIL bubble_cleared got=%b exp=0", out_error); end
      checks++; if (out_data !== 4'b0010) begin failures++; $display("FAIL bubble_next_data got=%b exp=0010", out_data); end
      handshake();
   endtask

   task automatic test_hold_stall();
      int bad = 0;
      send_frame(1'b1, 7'b1111100);
      // Offer a start beat while holding; it must be back-pressured.
      @(negedge clk); in_valid = 1'b1; in_start = 1'b1; in_bit = 1'b1; in_sign = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_error !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d exp=0 data=%b", bad, out_data); end
      @(negedge clk); in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0;
      handshake();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_gaps();
      logic [6:0] bits = 7'b1100000;
      drive_beat(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         drive_beat(i == 0, bits[6-i], 1'b0);
         repeat (2) @(posedge clk);
      end
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gaps_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'b0010) begin failures++; $display("FAIL gaps_data got=%b exp=0010", out_data); end
      handshake();
   endtask

   task automatic test_abort();
      logic [6:0] bits = 7'b1111111;
      int early = 0;
      for (int i = 0; i < 3; i++) begin
         drive_beat(i == 0, 1'b1, 1'b1);
         if (out_valid) early++;
      end
      for (int i = 0; i < 6; i++) begin
         drive_beat(i == 0, bits[6-i], 1'b0);
         if (out_valid) early++;
      end
      checks++; if (early !== 0) begin failures++; $display("FAIL abort_early_result cycles=%0d exp=0", early); end
      drive_beat(1'b0, bits[0], 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'b0111) begin failures++; $display("FAIL abort_data got=%b exp=0111", out_data); end
      handshake();
   endtask

   task automatic test_reset_midframe();
      send_frame(1'b0, 7'b1111000);
      @(negedge clk); rst = 1'b1; #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_hold_ready got=%b exp=1", in_ready); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) drive_beat(i == 0, 1'b1, 1'b0);
      @(negedge clk); rst = 1'b1; #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 4'b0000 || out_error !== 1'b0) begin
         failures++; $display("FAIL rst_mid_outputs got=%b/%b/%b exp=0/0000/0", out_valid, out_data, out_error); end
      @(negedge clk); rst = 1'b0;
      send_frame(1'b1, 7'b1000000);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_after_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'b1111) begin failures++; $display("FAIL rst_after_data got=%b exp=1111", out_data); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_bubble();
      test_hold_stall();
      test_gaps();
      test_abort();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
